// File: rtl/matmul_result_drain.sv
// Reads matrix C row by row after a done_mat_mul rising edge; each row costs 1 + RD_LATENCY + beats cycles.
// Rows are serialised into CHUNK_WORDS-wide beats that are held stable while out_ready is low.
module matmul_result_drain #(
  parameter int DWIDTH      = 16,
  parameter int ROW_WORDS   = 8,
  parameter int CHUNK_WORDS = 2,
  parameter int NUM_ROWS    = 16,
  parameter int AWIDTH      = 16,
  parameter int BASE_ADDR   = 0,
  parameter int RD_LATENCY  = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            done_mat_mul,
  output logic                            enable_reading_from_mem,
  output logic [AWIDTH-1:0]               addr_pi,
  input  logic [ROW_WORDS*DWIDTH-1:0]     data_from_out_mat,
  output logic [CHUNK_WORDS*DWIDTH-1:0]   out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            drain_done,
  output logic                            overrun
);

  localparam int ROW_BITS   = ROW_WORDS * DWIDTH;
  localparam int CHUNK_BITS = CHUNK_WORDS * DWIDTH;
  localparam int NUM_CHUNKS = ROW_WORDS / CHUNK_WORDS;
  localparam int RW = (NUM_ROWS > 1)   ? $clog2(NUM_ROWS)   : 1;
  localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [RW-1:0]     LAST_ROW   = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0]     LAST_CHUNK = CW'(NUM_CHUNKS - 1);
  localparam logic [AWIDTH-1:0] BASE       = AWIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SEND, S_DONE} state_t;

  state_t              state, state_nxt;
  logic                done_q;
  logic                start;
  logic                fire;
  logic                last_chunk;
  logic                last_row;
  logic [RW-1:0]       row;
  logic [CW-1:0]       chunk;
  logic [LW-1:0]       lat_cnt;
  logic [ROW_BITS-1:0] row_reg;

  assign start      = done_mat_mul & ~done_q;
  assign fire       = (state == S_SEND) & out_ready;
  assign last_chunk = (chunk == LAST_CHUNK);
  assign last_row   = (row == LAST_ROW);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (lat_cnt == '0) state_nxt = S_SEND;
      S_SEND:  if (fire && last_chunk) state_nxt = last_row ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done_q  <= 1'b0;
      overrun <= 1'b0;
      row     <= '0;
      chunk   <= '0;
      lat_cnt <= '0;
      addr_pi <= '0;
      row_reg <= '0;
    end else begin
      done_q <= done_mat_mul;
      // DONE still counts as busy, so an edge there is an overrun rather than a new drain
      if (start && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: if (start) row <= '0;
        S_ISSUE: begin
          addr_pi <= BASE + AWIDTH'(row);
          lat_cnt <= LW'(RD_LATENCY - 1);
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            row_reg <= data_from_out_mat;
            chunk   <= '0;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        S_SEND: begin
          if (fire) begin
            if (!last_chunk)    chunk <= chunk + CW'(1);
            else if (!last_row) row   <= row + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid               = (state == S_SEND);
    busy                    = (state != S_IDLE);
    enable_reading_from_mem = (state != S_IDLE);
    drain_done              = (state == S_DONE);
    out_last                = (state == S_SEND) & last_chunk & last_row;
    // chunk 0 sits in the LSBs of the captured row
    out_data                = CHUNK_BITS'(row_reg >> (CHUNK_BITS * chunk));
  end

endmodule

// File: tb/tb_matmul_result_drain.sv
// Directed bench for matmul_result_drain: default build plus a one-row, full-width-beat, latency-1 build.
module tb_matmul_result_drain;

  logic         clk = 1'b0;
  logic         resetn;
  logic         done1, rdy1, en1, vld1, last1, busy1, dd1, ovr1;
  logic [15:0]  addr1;
  logic [127:0] data1;
  logic [31:0]  odat1;
  logic         done2, rdy2, en2, vld2, last2, busy2, dd2, ovr2;
  logic [15:0]  addr2;
  logic [127:0] data2, odat2;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           mode    = 0;
  logic         use_noise;
  logic [127:0] noise;
  logic [15:0]  ap1, ap2, ap3;

  always #5 clk = ~clk;

  // mode 0: every word of row r is 0x0100+r; mode 1: word w of row r is {r, w}
  function automatic logic [127:0] row_of(input int m, input logic [15:0] r);
    logic [127:0] v;
    v = '0;
    for (int w = 0; w < 8; w++)
      v[w*16 +: 16] = (m == 0) ? (16'h0100 + r) : {r[7:0], 8'(w)};
    return v;
  endfunction

  // C RAM read model: three register stages behind addr_pi plus the DUT's own address register
  always @(posedge clk) begin
    ap1 <= addr1;
    ap2 <= ap1;
    ap3 <= ap2;
  end
  assign data1 = use_noise ? noise : row_of(mode, ap3);
  assign data2 = use_noise ? noise : row_of(1, addr2);

  matmul_result_drain u_dut (
    .clk(clk), .resetn(resetn), .done_mat_mul(done1),
    .enable_reading_from_mem(en1), .addr_pi(addr1), .data_from_out_mat(data1),
    .out_data(odat1), .out_valid(vld1), .out_ready(rdy1), .out_last(last1),
    .busy(busy1), .drain_done(dd1), .overrun(ovr1)
  );

  matmul_result_drain #(
    .CHUNK_WORDS(8), .RD_LATENCY(1), .NUM_ROWS(1), .BASE_ADDR(3)
  ) u_dut2 (
    .clk(clk), .resetn(resetn), .done_mat_mul(done2),
    .enable_reading_from_mem(en2), .addr_pi(addr2), .data_from_out_mat(data2),
    .out_data(odat2), .out_valid(vld2), .out_ready(rdy2), .out_last(last2),
    .busy(busy2), .drain_done(dd2), .overrun(ovr2)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full drain of the default build; pct = percent of cycles with out_ready low.
  // When pulse_row >= 0, done1 gets a fresh rising edge while that row is being sent.
  task automatic run_drain(input int pct, input int pulse_row, input string tag);
    int           beat = 0;
    int           cyc  = 0;
    int           r, c;
    bit           held  = 0;
    bit           first = 1;
    logic [31:0]  prev = '0;
    logic [127:0] er;
    @(negedge clk);
    done1 = 1'b1;
    while (beat < 64 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) done1 = 1'b0;
      rdy1 = (int'($urandom_range(99)) >= pct);
      if (held) chk({tag, "_hold"}, {vld1, odat1}, {1'b1, prev});
      if (vld1) begin
        if (first) begin
          chk({tag, "_first_valid_cycle"}, cyc, 6);
          chk({tag, "_en_busy"}, {en1, busy1}, 2'b11);
          first = 0;
        end
        r  = beat / 4;
        c  = beat % 4;
        er = row_of(mode, 16'(r));
        if (r == pulse_row && c == 0) done1 = 1'b1;
        if (rdy1) begin
          chk({tag, "_data"}, odat1, er[c*32 +: 32]);
          chk({tag, "_last"}, last1, (beat == 63));
          chk({tag, "_addr"}, addr1, 16'(r));
          beat++;
          held = 0;
        end else begin
          held = 1;
          prev = odat1;
        end
      end else begin
        held = 0;
      end
    end
    chk({tag, "_beat_count"}, beat, 64);
    @(negedge clk);
    chk({tag, "_drain_done_pulse"}, {dd1, busy1, vld1}, 3'b110);
    @(negedge clk);
    chk({tag, "_back_to_idle"}, {dd1, busy1, en1, vld1}, 4'b0000);
  endtask

  initial begin
    int seen;
    resetn    = 1'b0;
    use_noise = 1'b1;
    done1 = 1'b0; rdy1 = 1'b0; done2 = 1'b0; rdy2 = 1'b0;
    noise = '0;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      noise = {$urandom(), $urandom(), $urandom(), $urandom()};
      done1 = 1'($urandom_range(1)); rdy1 = 1'($urandom_range(1));
      done2 = 1'($urandom_range(1)); rdy2 = 1'($urandom_range(1));
      #1;
      chk("reset_outs1", {en1, vld1, last1, busy1, dd1, ovr1, addr1, odat1}, '0);
      chk("reset_outs2", {en2, vld2, last2, busy2, dd2, ovr2, addr2, odat2}, '0);
    end
    @(negedge clk);
    done1 = 1'b0; done2 = 1'b0; rdy1 = 1'b1; rdy2 = 1'b1;
    use_noise = 1'b0;
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy1 || en1 || vld1 || busy2 || en2 || vld2) seen++;
    end
    chk("idle_after_reset", seen, 0);

    // basic drain, then with backpressure
    mode = 0;
    run_drain(0, -1, "basic");
    run_drain(30, -1, "bp");
    chk("no_overrun_yet", ovr1, 1'b0);

    // start edge mid-drain (row 5), word-indexed rows to pin chunk order
    mode = 1;
    run_drain(20, 5, "ovr");
    chk("overrun_set", ovr1, 1'b1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy1) seen++;
    end
    chk("held_done_no_retrigger", seen, 0);
    chk("overrun_sticky", ovr1, 1'b1);
    done1 = 1'b0;
    @(negedge clk);

    // reset during SEND of row 3
    mode = 0;
    rdy1 = 1'b1;
    done1 = 1'b1;
    seen = 0;
    while (!(vld1 && addr1 == 16'd3) && seen < 500) begin
      @(negedge clk);
      seen++;
      if (seen == 2) done1 = 1'b0;
    end
    chk("reached_row3", addr1, 16'd3);
    resetn = 1'b0;
    #1;
    chk("mid_reset_outs", {en1, vld1, last1, busy1, dd1, ovr1, addr1, odat1}, '0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy1 || vld1 || dd1) seen++;
    end
    chk("idle_after_mid_reset", seen, 0);
    run_drain(0, -1, "post_reset");

    // single full-row beat, latency 1, base 3
    @(negedge clk);
    done2 = 1'b1;
    rdy2  = 1'b1;
    @(negedge clk);
    chk("p2_issue", {busy2, en2, vld2, addr2}, {3'b110, 16'd0});
    @(negedge clk);
    chk("p2_wait", {busy2, vld2, addr2}, {2'b10, 16'd3});
    @(negedge clk);
    chk("p2_beat_ctl", {vld2, last2, addr2}, {2'b11, 16'd3});
    chk("p2_beat_data", odat2, 128'h0307_0306_0305_0304_0303_0302_0301_0300);
    @(negedge clk);
    chk("p2_drain_done", {dd2, vld2, last2}, 3'b100);
    @(negedge clk);
    chk("p2_idle", {dd2, busy2, en2, ovr2}, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired: tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
